// File: rtl/i2s_tx.sv
// i2s_tx: standard-format I2S serialiser, 16-bit L/R pairs, one-entry holding buffer.
// Latency: an accepted pair is loaded on the next frame start; L[15] follows one BCK later (I2S delay).
// Backpressure: sample_ready = ~buf_full; an empty buffer at frame start raises a one-cycle underrun.
// Option: define I2S_TX_UNDERRUN_HOLD_EN to repeat the last loaded pair on underrun instead of silence.
module i2s_tx #(
   parameter int CLK_DIV = 16
) (
   input  logic        clk_50MHz,
   input  logic        reset,
   input  logic [15:0] l_data,
   input  logic [15:0] r_data,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        underrun,
   output logic        I2S_BCK,
   output logic        I2S_LRCK,
   output logic        I2S_DATA
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          bck_q, bck_d;
   logic          lrck_q, lrck_d;
   logic          data_q, data_d;
   logic [4:0]    slot_q, slot_d;
   logic [31:0]   frame_q, frame_d;
   logic [15:0]   buf_l_q, buf_l_d;
   logic [15:0]   buf_r_q, buf_r_d;
   logic          buf_full_q, buf_full_d;
   logic          underrun_q, underrun_d;
   logic [31:0]   fill;

   logic          tick;
   logic          fe;
   logic          load;
   logic          accept;
   logic [4:0]    slot_inc;
   logic [4:0]    bit_idx;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
   logic [31:0]   last_q, last_d;

   // Remember every pair that came from the buffer so an underrun can repeat it.
   always_comb begin
      last_d = last_q;
      if (load && buf_full_q) begin
         last_d = {buf_l_q, buf_r_q};
      end
   end

   assign fill = last_q;
`else
   assign fill = 32'h0;
`endif

   // Event decode: divider wrap, falling BCK edge, and the frame-start edge.
   always_comb begin
      tick     = (div_q == DIV_LAST);
      fe       = tick & bck_q;
      slot_inc = slot_q + 5'd1;
      load     = fe & (slot_inc == 5'd0);
      accept   = sample_valid & ~buf_full_q;
      // Slot s carries frame[32-s]; modulo 32 this also maps slot 0 to frame[0] (previous R LSB).
      bit_idx  = 5'd0 - slot_inc;
   end

   // Bit-clock divider and serial outputs; everything except BCK moves only on the falling edge.
   always_comb begin
      div_d  = tick ? '0 : div_q + DW'(1);
      bck_d  = tick ? ~bck_q : bck_q;
      slot_d = slot_q;
      lrck_d = lrck_q;
      data_d = data_q;
      if (fe) begin
         slot_d = slot_inc;
         lrck_d = slot_inc[4];
         data_d = frame_q[bit_idx];
      end
   end

   // Frame load at slot 0: buffered pair if present, otherwise the underrun fill pattern.
   always_comb begin
      frame_d    = frame_q;
      underrun_d = load & ~buf_full_q;
      if (load) begin
         frame_d = buf_full_q ? {buf_l_q, buf_r_q} : fill;
      end
   end

   // Holding buffer: a same-cycle accept wins over the load's clear, so the new pair stays held.
   always_comb begin
      buf_l_d    = buf_l_q;
      buf_r_d    = buf_r_q;
      buf_full_d = buf_full_q;
      if (load) begin
         buf_full_d = 1'b0;
      end
      if (accept) begin
         buf_l_d    = l_data;
         buf_r_d    = r_data;
         buf_full_d = 1'b1;
      end
   end

   // State registers with synchronous reset; reset abandons the frame and drops any buffered pair.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         div_q      <= '0;
         bck_q      <= 1'b0;
         lrck_q     <= 1'b1;
         data_q     <= 1'b0;
         slot_q     <= 5'd31;
         frame_q    <= 32'h0;
         buf_l_q    <= 16'h0;
         buf_r_q    <= 16'h0;
         buf_full_q <= 1'b0;
         underrun_q <= 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
         last_q     <= 32'h0;
`endif
      end else begin
         div_q      <= div_d;
         bck_q      <= bck_d;
         lrck_q     <= lrck_d;
         data_q     <= data_d;
         slot_q     <= slot_d;
         frame_q    <= frame_d;
         buf_l_q    <= buf_l_d;
         buf_r_q    <= buf_r_d;
         buf_full_q <= buf_full_d;
         underrun_q <= underrun_d;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
         last_q     <= last_d;
`endif
      end
   end

   assign sample_ready = ~buf_full_q;
   assign underrun     = underrun_q;
   assign I2S_BCK      = bck_q;
   assign I2S_LRCK     = lrck_q;
   assign I2S_DATA     = data_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at CLK_DIV = 16: reset, framing, backpressure, underrun, mid-frame reset.
// Cycle n means the state sampled 1 time unit after the n-th rising edge following reset release.
// Falling BCK edges land on cycles 32k; slot s of a frame loaded at cycle B is driven at B + 32*s.
module tb_i2s_tx;
   localparam int CLK_DIV = 16;

   logic        clk_50MHz = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] l_data = 16'h0;
   logic [15:0] r_data = 16'h0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        underrun;
   logic        I2S_BCK;
   logic        I2S_LRCK;
   logic        I2S_DATA;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk_50MHz = ~clk_50MHz;

   i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
      .clk_50MHz   (clk_50MHz),
      .reset       (reset),
      .l_data      (l_data),
      .r_data      (r_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .underrun    (underrun),
      .I2S_BCK     (I2S_BCK),
      .I2S_LRCK    (I2S_LRCK),
      .I2S_DATA    (I2S_DATA)
   );

   task automatic step();
      @(posedge clk_50MHz);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      sample_valid = 1'b0;
      repeat (n) step();
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic present(input logic [15:0] l, input logic [15:0] r);
      l_data = l;
      r_data = r;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
   endtask

   // Collect slots 1..31 of the frame loaded at cycle base (MSB = slot 1), the LRCK
   // pattern, and whether DATA/LRCK held steady with BCK high mid-slot.
   task automatic capture(input int base, output logic [30:0] w, output logic [30:0] lr,
                          output logic stable);
      logic d, l;
      w = '0;
      lr = '0;
      stable = 1'b1;
      for (int s = 1; s < 32; s++) begin
         run_to(base + 32 * s);
         d = I2S_DATA;
         l = I2S_LRCK;
         w = {w[29:0], d};
         lr = {lr[29:0], l};
         run_to(base + 32 * s + 16);
         if (I2S_DATA !== d || I2S_LRCK !== l || I2S_BCK !== 1'b1) stable = 1'b0;
      end
   endtask

   initial begin
      logic [30:0] w, lr;
      logic        stable;
      logic        nz;
      int          acc, rdy_hi, un;
      int          acc_edge[8];
      logic        took;

      // Reset defaults, no samples offered.
      do_reset(3);
      chk("rst_bck", I2S_BCK, 0);
      chk("rst_lrck", I2S_LRCK, 1);
      chk("rst_data", I2S_DATA, 0);
      chk("rst_ready", sample_ready, 1);
      chk("rst_underrun", underrun, 0);
      run_to(15);
      chk("bck_before_rise", I2S_BCK, 0);
      run_to(16);
      chk("bck_first_rise", I2S_BCK, 1);
      run_to(31);
      chk("lrck_before_fe", I2S_LRCK, 1);
      chk("underrun_before_fe", underrun, 0);
      run_to(32);
      chk("lrck_first_fe", I2S_LRCK, 0);
      chk("underrun_first_fe", underrun, 1);
      chk("bck_first_fe", I2S_BCK, 0);
      step();
      chk("underrun_one_cycle", underrun, 0);
      nz = 1'b0;
      while (cyc < 1055) begin
         step();
         if (I2S_DATA !== 1'b0) nz = 1'b1;
      end
      chk("silent_frame_data", nz, 0);

      // Basic frame A5C3 / 3C5A.
      do_reset(3);
      present(16'hA5C3, 16'h3C5A);
      chk("basic_ready_low", sample_ready, 0);
      run_to(32);
      chk("basic_no_underrun", underrun, 0);
      run_to(33);
      chk("basic_ready_back", sample_ready, 1);
      capture(32, w, lr, stable);
      chk("basic_bits", w, 31'h52E19E2D);
      chk("basic_lrck", lr, 31'h0000FFFF);
      chk("basic_stable", stable, 1);
      run_to(1056);
      chk("basic_r_lsb_slot0", I2S_DATA, 0);
      chk("basic_next_underrun", underrun, 1);

      // Backpressure: valid held with an incrementing pair.
      do_reset(3);
      l_data = 16'h0100;
      r_data = 16'h0200;
      sample_valid = 1'b1;
      acc = 0;
      rdy_hi = 0;
      un = 0;
      while (cyc < 4000) begin
         took = sample_ready;
         if (took) begin
            rdy_hi++;
            if (acc < 8) acc_edge[acc] = cyc + 1;
            acc++;
         end
         step();
         if (took) begin
            l_data = l_data + 16'h1;
            r_data = r_data + 16'h1;
         end
         if (underrun) un++;
      end
      sample_valid = 1'b0;
      chk("bp_accepts", acc, 5);
      chk("bp_ready_high_cycles", rdy_hi, 5);
      chk("bp_period_a", acc_edge[2] - acc_edge[1], 1024);
      chk("bp_period_b", acc_edge[3] - acc_edge[2], 1024);
      chk("bp_no_underrun", un, 0);

      // Valid asserted across the loading edge while the buffer is full.
      do_reset(3);
      present(16'h0001, 16'h0002);
      run_to(33);
      present(16'h1234, 16'h5678);
      run_to(1050);
      l_data = 16'hFEDC;
      r_data = 16'hBA98;
      sample_valid = 1'b1;
      run_to(1055);
      chk("sim_ready_full", sample_ready, 0);
      run_to(1056);
      chk("sim_no_underrun", underrun, 0);
      run_to(1057);
      chk("sim_new_pair_held", sample_ready, 0);
      sample_valid = 1'b0;
      capture(1056, w, lr, stable);
      chk("sim_old_pair_bits", w, 31'h091A2B3C);
      run_to(2080);
      chk("sim_second_no_underrun", underrun, 0);
      capture(2080, w, lr, stable);
      chk("sim_new_pair_bits", w, 31'h7F6E5D4C);

      // Underrun after 7FFF / 8001.
      do_reset(3);
      present(16'h7FFF, 16'h8001);
      capture(32, w, lr, stable);
      chk("ur_first_frame", w, 31'h3FFFC000);
      run_to(1056);
      chk("ur_r_lsb", I2S_DATA, 1);
      chk("ur_pulse", underrun, 1);
      step();
      chk("ur_pulse_end", underrun, 0);
      capture(1056, w, lr, stable);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      chk("ur_fill_frame", w, 31'h3FFFC000);
`else
      chk("ur_fill_frame", w, 31'h0);
`endif

      // Reset in the middle of a frame with a pair still buffered.
      do_reset(3);
      present(16'h1111, 16'h2222);
      run_to(40);
      present(16'h3333, 16'h4444);
      run_to(672);
      chk("mid_lrck_slot20", I2S_LRCK, 1);
      chk("mid_buffer_full", sample_ready, 0);
      run_to(680);
      reset = 1'b1;
      step();
      chk("mid_rst_bck", I2S_BCK, 0);
      chk("mid_rst_lrck", I2S_LRCK, 1);
      chk("mid_rst_data", I2S_DATA, 0);
      chk("mid_rst_ready", sample_ready, 1);
      chk("mid_rst_underrun", underrun, 0);
      step();
      step();
      reset = 1'b0;
      cyc = 0;
      run_to(31);
      chk("mid_restart_lrck_pre", I2S_LRCK, 1);
      chk("mid_restart_bck_pre", I2S_BCK, 1);
      run_to(32);
      chk("mid_restart_lrck", I2S_LRCK, 0);
      chk("mid_restart_underrun", underrun, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
